// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester single-port RAM arbiter (IDLE/ACCESS/RDATA FSM)
// Round-robin by default; define RAM_ARB_FIXED_PRIO_EN for fixed priority with port 0 winning ties.
module ram_arbiter #(
  parameter int N = 3,
  parameter int M = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         we0,
  input  logic [M:0]   addr0,
  input  logic [N:0]   wdata0,
  output logic         gnt0,
  output logic         rvalid0,
  output logic [N:0]   rdata0,
  input  logic         req1,
  input  logic         we1,
  input  logic [M:0]   addr1,
  input  logic [N:0]   wdata1,
  output logic         gnt1,
  output logic         rvalid1,
  output logic [N:0]   rdata1,
  output logic [N:0]   ram_data,
  output logic [M:0]   ram_address,
  output logic         ram_we,
  input  logic [N:0]   ram_q,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } state_t;

  state_t       state_q;
  logic         id_q;
  logic         we_q;
  logic [M:0]   addr_q;
  logic [N:0]   wdata_q;
  logic         gnt0_q;
  logic         gnt1_q;
  logic         rvalid0_q;
  logic         rvalid1_q;
  logic [N:0]   rdata0_q;
  logic [N:0]   rdata1_q;
  logic         ram_we_q;
  logic         busy_q;

  logic         win_d;
  logic         sel_we_d;
  logic [M:0]   sel_addr_d;
  logic [N:0]   sel_wdata_d;

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign win_d = ~req0;
`else
  logic last_q;

  // On a tie the port that was not granted last wins; a lone request always wins.
  assign win_d = (req0 & req1) ? ~last_q : req1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (state_q == IDLE && (req0 || req1)) begin
      last_q <= win_d;
    end
  end
`endif

  assign sel_we_d    = win_d ? we1    : we0;
  assign sel_addr_d  = win_d ? addr1  : addr0;
  assign sel_wdata_d = win_d ? wdata1 : wdata0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      id_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      ram_we_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      ram_we_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            id_q     <= win_d;
            we_q     <= sel_we_d;
            addr_q   <= sel_addr_d;
            wdata_q  <= sel_wdata_d;
            gnt0_q   <= ~win_d;
            gnt1_q   <= win_d;
            ram_we_q <= sel_we_d;
            busy_q   <= 1'b1;
            state_q  <= ACCESS;
          end
        end
        ACCESS: begin
          // A write commits on this edge; a read waits one cycle for ram_q.
          if (we_q) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            state_q <= RDATA;
          end
        end
        RDATA: begin
          if (id_q) begin
            rdata1_q  <= ram_q;
            rvalid1_q <= 1'b1;
          end else begin
            rdata0_q  <= ram_q;
            rvalid0_q <= 1'b1;
          end
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign rvalid0     = rvalid0_q;
  assign rvalid1     = rvalid1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign ram_data    = wdata_q;
  assign ram_address = addr_q;
  assign ram_we      = ram_we_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - randomized and directed bench for ram_arbiter against a transaction-level model
// Honours RAM_ARB_FIXED_PRIO_EN in its arbitration model.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0 = '0, addr1 = '0;
  logic [3:0] wdata0 = '0, wdata1 = '0;
  logic       gnt0, gnt1, rvalid0, rvalid1, ram_we, busy;
  logic [3:0] rdata0, rdata1, ram_data, ram_q;
  logic [7:0] ram_address;

  int vectors = 0;
  int miscompares = 0;

  // Environment RAM: address registered on each edge, read data from that address.
  logic [3:0] ram_mem [256] = '{default: 4'h0};
  logic [7:0] ram_addr_r = '0;
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_address] <= ram_data;
    ram_addr_r <= ram_address;
  end
  assign ram_q = ram_mem[ram_addr_r];

  // Reference model state
  logic [3:0] m_mem [256] = '{default: 4'h0};
  logic [3:0] m_rdata [2];
  logic       m_last;

  always #5 clk = ~clk;

  ram_arbiter #(.N(3), .M(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .ram_data(ram_data), .ram_address(ram_address), .ram_we(ram_we),
    .ram_q(ram_q), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic pick(input logic r0, input logic r1);
    if (r0 && r1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      return 1'b0;
`else
      return m_last ? 1'b0 : 1'b1;
`endif
    end
    return r1;
  endfunction

  task automatic reset_dut();
    rst_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_last = 1'b1;
    m_rdata[0] = 4'h0;
    m_rdata[1] = 4'h0;
    chk("rst_gnt0", 32'(gnt0), 32'(1'b0));
    chk("rst_gnt1", 32'(gnt1), 32'(1'b0));
    chk("rst_rvalid0", 32'(rvalid0), 32'(1'b0));
    chk("rst_rvalid1", 32'(rvalid1), 32'(1'b0));
    chk("rst_ram_we", 32'(ram_we), 32'(1'b0));
    chk("rst_busy", 32'(busy), 32'(1'b0));
    chk("rst_ram_address", 32'(ram_address), 32'(8'h00));
    chk("rst_ram_data", 32'(ram_data), 32'(4'h0));
    chk("rst_rdata0", 32'(rdata0), 32'(4'h0));
    chk("rst_rdata1", 32'(rdata1), 32'(4'h0));
    rst_n = 1'b1;
  endtask

  // One request window starting from IDLE; requests drop right after the sampling edge.
  task automatic txn(input logic r0, input logic r1, input logic w0, input logic w1,
                     input logic [7:0] a0, input logic [7:0] a1,
                     input logic [3:0] d0, input logic [3:0] d1);
    logic       w;
    logic       ww;
    logic [7:0] wa;
    logic [3:0] wd;
    req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    @(posedge clk);
    #1;
    req0 = 1'b0;
    req1 = 1'b0;
    if (!r0 && !r1) begin
      chk("idle_gnt0", 32'(gnt0), 32'(1'b0));
      chk("idle_gnt1", 32'(gnt1), 32'(1'b0));
      chk("idle_busy", 32'(busy), 32'(1'b0));
      chk("idle_ram_we", 32'(ram_we), 32'(1'b0));
      return;
    end
    w  = pick(r0, r1);
    m_last = w;
    ww = w ? w1 : w0;
    wa = w ? a1 : a0;
    wd = w ? d1 : d0;
    chk("gnt0", 32'(gnt0), 32'(!w));
    chk("gnt1", 32'(gnt1), 32'(w));
    chk("acc_busy", 32'(busy), 32'(1'b1));
    chk("acc_ram_we", 32'(ram_we), 32'(ww));
    chk("acc_ram_address", 32'(ram_address), 32'(wa));
    chk("acc_ram_data", 32'(ram_data), 32'(wd));
    chk("acc_rvalid0", 32'(rvalid0), 32'(1'b0));
    chk("acc_rvalid1", 32'(rvalid1), 32'(1'b0));
    if (ww) begin
      @(posedge clk);
      #1;
      m_mem[wa] = wd;
      chk("wr_done_ram_we", 32'(ram_we), 32'(1'b0));
      chk("wr_done_busy", 32'(busy), 32'(1'b0));
      chk("wr_done_gnt", 32'({gnt1, gnt0}), 32'(2'b00));
      chk("wr_done_rvalid", 32'({rvalid1, rvalid0}), 32'(2'b00));
    end else begin
      @(posedge clk);
      #1;
      chk("rd_ram_we", 32'(ram_we), 32'(1'b0));
      chk("rd_busy", 32'(busy), 32'(1'b1));
      chk("rd_ram_address", 32'(ram_address), 32'(wa));
      chk("rd_rvalid", 32'({rvalid1, rvalid0}), 32'(2'b00));
      @(posedge clk);
      #1;
      m_rdata[w] = m_mem[wa];
      chk("rvalid0", 32'(rvalid0), 32'(!w));
      chk("rvalid1", 32'(rvalid1), 32'(w));
      chk("rdata0", 32'(rdata0), 32'(m_rdata[0]));
      chk("rdata1", 32'(rdata1), 32'(m_rdata[1]));
      chk("rd_done_busy", 32'(busy), 32'(1'b0));
    end
  endtask

  function automatic logic [7:0] rand_addr();
    logic [7:0] a;
    a = 8'($urandom_range(0, 7));
    if ($urandom_range(0, 1) == 1) a = a | 8'hF8;
    return a;
  endfunction

  initial begin
    logic       pw;
    int         gnt_cnt;
    int         we_cnt;
    m_last = 1'b1;
    m_rdata[0] = 4'h0;
    m_rdata[1] = 4'h0;
    pw = 1'b0;

    reset_dut();

    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("quiet_ram_we", 32'(ram_we), 32'(1'b0));
      chk("quiet_busy", 32'(busy), 32'(1'b0));
      chk("quiet_gnt", 32'({gnt1, gnt0}), 32'(2'b00));
    end

    txn(1'b1, 1'b0, 1'b1, 1'b0, 8'h05, 8'h00, 4'hA, 4'h0);
    txn(1'b1, 1'b0, 1'b0, 1'b0, 8'h05, 8'h00, 4'h0, 4'h0);
    chk("wr_rd_p0_rdata0", 32'(rdata0), 32'(4'hA));

    txn(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'hFF, 4'h0, 4'h3);
    txn(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 4'h0, 4'h0);
    chk("p1_wr_p0_rd_rdata0", 32'(rdata0), 32'(4'h3));

    for (int i = 0; i < 80; i++) begin
      txn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          rand_addr(), rand_addr(), 4'($urandom), 4'($urandom));
    end

    // Held write request: one grant and one ram_we cycle every 2 cycles
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h40; wdata0 = 4'h6;
    gnt_cnt = 0;
    we_cnt = 0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk);
      #1;
      if (e % 2 == 0) m_mem[8'h40] = 4'h6;
      chk("b2b_ram_we", 32'(ram_we), 32'(e % 2 == 0));
      chk("b2b_gnt0", 32'(gnt0), 32'(e % 2 == 0));
      gnt_cnt += int'(gnt0);
      we_cnt += int'(ram_we);
      if (e == 6) req0 = 1'b0;
    end
    chk("b2b_we_per_write", 32'(we_cnt), 32'(gnt_cnt));
    chk("b2b_gnt_count", 32'(gnt_cnt), 32'(4));

    // Both reads held from reset release
    reset_dut();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'hFF;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk);
      #1;
      if (e % 3 == 0) begin
        pw = pick(1'b1, 1'b1);
        m_last = pw;
        chk("held_gnt0", 32'(gnt0), 32'(!pw));
        chk("held_gnt1", 32'(gnt1), 32'(pw));
      end else begin
        chk("held_no_gnt", 32'({gnt1, gnt0}), 32'(2'b00));
      end
      if (e % 3 == 2) begin
        m_rdata[pw] = m_mem[pw ? 8'hFF : 8'h05];
        chk("held_rvalid0", 32'(rvalid0), 32'(!pw));
        chk("held_rvalid1", 32'(rvalid1), 32'(pw));
        chk("held_rdata0", 32'(rdata0), 32'(m_rdata[0]));
        chk("held_rdata1", 32'(rdata1), 32'(m_rdata[1]));
      end else begin
        chk("held_no_rvalid", 32'({rvalid1, rvalid0}), 32'(2'b00));
      end
      if (e == 11) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("held_end_busy", 32'(busy), 32'(1'b0));

    // Reset during RDATA of a port-1 read
    reset_dut();
    txn(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h77, 4'h0, 4'h9);
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h77;
    @(posedge clk);
    #1;
    req1 = 1'b0;
    chk("abort_gnt1", 32'(gnt1), 32'(1'b1));
    @(posedge clk);
    #1;
    chk("abort_in_rdata_busy", 32'(busy), 32'(1'b1));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_last = 1'b1;
    m_rdata[0] = 4'h0;
    m_rdata[1] = 4'h0;
    chk("abort_rvalid1", 32'(rvalid1), 32'(1'b0));
    chk("abort_busy", 32'(busy), 32'(1'b0));
    chk("abort_rdata1", 32'(rdata1), 32'(4'h0));
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      #1;
      chk("abort_after_rvalid1", 32'(rvalid1), 32'(1'b0));
      chk("abort_after_busy", 32'(busy), 32'(1'b0));
    end

    // Data written before the aborted read is still in RAM
    txn(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h77, 4'h0, 4'h0);
    chk("post_abort_rdata1", 32'(rdata1), 32'(4'h9));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule
